// File: rtl/ghost_move_scheduler_if.sv
// Bus between the ghost move scheduler and its environment (frame timing, controllers, renderer).
// GHOST_BOUNDS_CHECK_EN adds the bad_move grant-reject strobe.
`timescale 1ns/1ps
interface ghost_move_scheduler_if #(
  parameter int NUM_GHOSTS = 4
);
  logic                      frame_tick;
  logic                      power_pellet;
  logic [9:0]                pac_x;
  logic [8:0]                pac_y;
  logic [10*NUM_GHOSTS-1:0]  nxt_x;
  logic [9*NUM_GHOSTS-1:0]   nxt_y;
  logic [9:0]                cur_x;
  logic [8:0]                cur_y;
  logic [NUM_GHOSTS-1:0]     step;
  logic [10*NUM_GHOSTS-1:0]  ghost_x;
  logic [9*NUM_GHOSTS-1:0]   ghost_y;
  logic                      frightened;
  logic [NUM_GHOSTS-1:0]     hit;
`ifdef GHOST_BOUNDS_CHECK_EN
  logic [NUM_GHOSTS-1:0]     bad_move;

  modport master (
    input  frame_tick, power_pellet, pac_x, pac_y, nxt_x, nxt_y,
    output cur_x, cur_y, step, ghost_x, ghost_y, frightened, hit, bad_move
  );
  modport slave (
    output frame_tick, power_pellet, pac_x, pac_y, nxt_x, nxt_y,
    input  cur_x, cur_y, step, ghost_x, ghost_y, frightened, hit, bad_move
  );
`else
  modport master (
    input  frame_tick, power_pellet, pac_x, pac_y, nxt_x, nxt_y,
    output cur_x, cur_y, step, ghost_x, ghost_y, frightened, hit
  );
  modport slave (
    output frame_tick, power_pellet, pac_x, pac_y, nxt_x, nxt_y,
    input  cur_x, cur_y, step, ghost_x, ghost_y, frightened, hit
  );
`endif
endinterface

// File: rtl/ghost_move_scheduler.sv
// Owns committed ghost positions, grants one movement controller at a time per step period,
// runs the frightened timer and flags ghost/Pac-Man collisions. Option macro: GHOST_BOUNDS_CHECK_EN.
`timescale 1ns/1ps
module ghost_move_scheduler #(
  parameter int                        NUM_GHOSTS    = 4,
  parameter int                        STEP_FRAMES   = 8,
  parameter int                        FRIGHT_FRAMES = 360,
  parameter logic [10*NUM_GHOSTS-1:0]  HOME_XS       = {NUM_GHOSTS{10'd600}},
  parameter logic [9*NUM_GHOSTS-1:0]   HOME_YS       = {NUM_GHOSTS{9'd320}}
`ifdef GHOST_BOUNDS_CHECK_EN
  ,
  parameter logic [9:0]                BX0           = 10'd0,
  parameter logic [9:0]                BX1           = 10'd620,
  parameter logic [8:0]                BY0           = 9'd0,
  parameter logic [8:0]                BY1           = 9'd460
`endif
) (
  input  logic                   clk,
  input  logic                   reset,
  ghost_move_scheduler_if.master bus_if
);

  localparam int IDX_W = (NUM_GHOSTS > 1) ? $clog2(NUM_GHOSTS) : 1;
  localparam int FC_W  = $clog2(2*STEP_FRAMES + 1) + 1;
  localparam int FR_W  = $clog2(FRIGHT_FRAMES + 1) + 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_GHOSTS - 1);

  typedef enum logic [1:0] {S_WAIT, S_ISSUE, S_CAPTURE} state_t;

  state_t                state_q, state_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [FC_W-1:0]       fc_q, fc_d, fc_inc, period;
  logic [FR_W-1:0]       fr_q, fr_d;
  logic                  frightened;
  logic                  round_start;
  logic [9:0]            gx_q [NUM_GHOSTS];
  logic [9:0]            gx_d [NUM_GHOSTS];
  logic [8:0]            gy_q [NUM_GHOSTS];
  logic [8:0]            gy_d [NUM_GHOSTS];
  logic [9:0]            cx_q, cx_d;
  logic [8:0]            cy_q, cy_d;
  logic [NUM_GHOSTS-1:0] step_q, step_d;
  logic [NUM_GHOSTS-1:0] hit_q, hit_d;
  logic [NUM_GHOSTS-1:0] bad_q, bad_d;
  logic [9:0]            prop_x, commit_x;
  logic [8:0]            prop_y, commit_y;
  logic                  move_ok;

  // Period doubles while frightened; evaluated only when a round may start.
  assign frightened  = (fr_q != '0);
  assign period      = frightened ? FC_W'(2*STEP_FRAMES) : FC_W'(STEP_FRAMES);
  assign fc_inc      = fc_q + FC_W'(bus_if.frame_tick);
  assign round_start = (state_q == S_WAIT) && (fc_inc >= period);

  assign prop_x = bus_if.nxt_x[10*int'(idx_q) +: 10];
  assign prop_y = bus_if.nxt_y[9*int'(idx_q) +: 9];

`ifdef GHOST_BOUNDS_CHECK_EN
  assign move_ok = (prop_x >= BX0) && (prop_x <= BX1) &&
                   (prop_y >= BY0) && (prop_y <= BY1) &&
                   ((prop_x % 10'd20) == 10'd0) && ((prop_y % 9'd20) == 9'd0);
`else
  assign move_ok = 1'b1;
`endif

  assign commit_x = move_ok ? prop_x : gx_q[idx_q];
  assign commit_y = move_ok ? prop_y : gy_q[idx_q];

  // ---- FSM state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_WAIT;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // ---- FSM next state
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    unique case (state_q)
      S_WAIT: begin
        if (round_start) begin
          state_d = S_ISSUE;
          idx_d   = '0;
        end
      end
      S_ISSUE: state_d = S_CAPTURE;
      S_CAPTURE: begin
        if (idx_q == LAST_IDX) begin
          state_d = S_WAIT;
        end else begin
          state_d = S_ISSUE;
          idx_d   = idx_q + 1'b1;
        end
      end
      default: state_d = S_WAIT;
    endcase
  end

  // ---- FSM outputs and datapath next values
  always_comb begin
    gx_d   = gx_q;
    gy_d   = gy_q;
    cx_d   = cx_q;
    cy_d   = cy_q;
    step_d = '0;
    hit_d  = '0;
    bad_d  = '0;

    // Ticks landing mid-round keep counting but cannot overrun the period.
    if (round_start)
      fc_d = '0;
    else if ((state_q != S_WAIT) && (fc_inc > period))
      fc_d = period;
    else
      fc_d = fc_inc;

    if (bus_if.power_pellet)
      fr_d = FR_W'(FRIGHT_FRAMES);
    else if (bus_if.frame_tick && frightened)
      fr_d = fr_q - 1'b1;
    else
      fr_d = fr_q;

    unique case (state_q)
      S_ISSUE: begin
        cx_d          = gx_q[idx_q];
        cy_d          = gy_q[idx_q];
        step_d[idx_q] = 1'b1;
      end
      S_CAPTURE: begin
        gx_d[idx_q]  = commit_x;
        gy_d[idx_q]  = commit_y;
        hit_d[idx_q] = (commit_x == bus_if.pac_x) && (commit_y == bus_if.pac_y);
        bad_d[idx_q] = !move_ok;
      end
      default: ;
    endcase
  end

  // ---- registered datapath
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int g = 0; g < NUM_GHOSTS; g++) begin
        gx_q[g] <= HOME_XS[10*g +: 10];
        gy_q[g] <= HOME_YS[9*g +: 9];
      end
      cx_q   <= '0;
      cy_q   <= '0;
      step_q <= '0;
      hit_q  <= '0;
      bad_q  <= '0;
      fc_q   <= '0;
      fr_q   <= '0;
    end else begin
      gx_q   <= gx_d;
      gy_q   <= gy_d;
      cx_q   <= cx_d;
      cy_q   <= cy_d;
      step_q <= step_d;
      hit_q  <= hit_d;
      bad_q  <= bad_d;
      fc_q   <= fc_d;
      fr_q   <= fr_d;
    end
  end

  assign bus_if.cur_x      = cx_q;
  assign bus_if.cur_y      = cy_q;
  assign bus_if.step       = step_q;
  assign bus_if.hit        = hit_q;
  assign bus_if.frightened = frightened;

  for (genvar g = 0; g < NUM_GHOSTS; g++) begin : g_pack
    assign bus_if.ghost_x[10*g +: 10] = gx_q[g];
    assign bus_if.ghost_y[9*g +: 9]   = gy_q[g];
  end

`ifdef GHOST_BOUNDS_CHECK_EN
  assign bus_if.bad_move = bad_q;
`else
  logic unused_bad;
  assign unused_bad = ^bad_q;
`endif

endmodule

// File: tb/tb_ghost_move_scheduler.sv
// Bench for ghost_move_scheduler: table-driven rounds, hand-written corner sequences and
// randomized frames checked every cycle against a round-position reference model.
`timescale 1ns/1ps
module tb_ghost_move_scheduler;
  localparam int NG = 4;
  localparam int SF = 8;
  localparam int FF = 4;
  localparam logic [39:0] HX = {4{10'd600}};
  localparam logic [35:0] HY = {4{9'd320}};

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ghost_move_scheduler_if #(.NUM_GHOSTS(NG)) bif ();

  ghost_move_scheduler #(
    .NUM_GHOSTS(NG), .STEP_FRAMES(SF), .FRIGHT_FRAMES(FF), .HOME_XS(HX), .HOME_YS(HY)
  ) dut (
    .clk(clk), .reset(rst_n), .bus_if(bif)
  );

  int n_cmp = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: position within a round (-1 idle, 2*i issue, 2*i+1 capture of ghost i).
  int               m_pos, m_fc, m_fr;
  logic [9:0]       m_gx [NG];
  logic [8:0]       m_gy [NG];
  logic [9:0]       m_cx;
  logic [8:0]       m_cy;
  logic [NG-1:0]    m_step, m_hit, m_bad;

`ifdef GHOST_BOUNDS_CHECK_EN
  function automatic bit legal(input logic [9:0] x, input logic [8:0] y);
    return (x <= 10'd620) && (y <= 9'd460) && (x % 20 == 0) && (y % 20 == 0);
  endfunction
`endif

  task automatic model_step();
    int per, idx, tk;
    logic [9:0] nx;
    logic [8:0] ny;
    bit ok;
    if (!rst_n) begin
      m_pos = -1; m_fc = 0; m_fr = 0;
      for (int g = 0; g < NG; g++) begin
        m_gx[g] = HX[10*g +: 10];
        m_gy[g] = HY[9*g +: 9];
      end
      m_cx = '0; m_cy = '0; m_step = '0; m_hit = '0; m_bad = '0;
    end else begin
      tk  = int'(bif.frame_tick);
      per = (m_fr != 0) ? 2*SF : SF;
      m_step = '0; m_hit = '0; m_bad = '0;
      if (m_pos < 0) begin
        if (m_fc + tk >= per) begin
          m_fc = 0; m_pos = 0;
        end else begin
          m_fc = m_fc + tk;
        end
      end else begin
        m_fc = (m_fc + tk > per) ? per : m_fc + tk;
        idx  = m_pos / 2;
        if (m_pos % 2 == 0) begin
          m_cx = m_gx[idx]; m_cy = m_gy[idx];
          m_step[idx] = 1'b1;
        end else begin
          nx = bif.nxt_x[10*idx +: 10];
          ny = bif.nxt_y[9*idx +: 9];
          ok = 1'b1;
`ifdef GHOST_BOUNDS_CHECK_EN
          ok = legal(nx, ny);
`endif
          if (ok) begin
            m_gx[idx] = nx; m_gy[idx] = ny;
          end else begin
            m_bad[idx] = 1'b1;
          end
          if (m_gx[idx] == bif.pac_x && m_gy[idx] == bif.pac_y) m_hit[idx] = 1'b1;
        end
        m_pos = (m_pos == 2*NG-1) ? -1 : m_pos + 1;
      end
      if (bif.power_pellet) m_fr = FF;
      else if (tk == 1 && m_fr > 0) m_fr = m_fr - 1;
    end
  endtask

  always @(posedge clk or negedge rst_n) model_step();

  function automatic logic [39:0] m_gxp();
    logic [39:0] r;
    for (int g = 0; g < NG; g++) r[10*g +: 10] = m_gx[g];
    return r;
  endfunction

  function automatic logic [35:0] m_gyp();
    logic [35:0] r;
    for (int g = 0; g < NG; g++) r[9*g +: 9] = m_gy[g];
    return r;
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_cur_x", bif.cur_x, m_cx);
      chk("m_cur_y", bif.cur_y, m_cy);
      chk("m_step", bif.step, m_step);
      chk("m_hit", bif.hit, m_hit);
      chk("m_ghost_x", bif.ghost_x, m_gxp());
      chk("m_ghost_y", bif.ghost_y, m_gyp());
      chk("m_frightened", bif.frightened, m_fr != 0);
`ifdef GHOST_BOUNDS_CHECK_EN
      chk("m_bad_move", bif.bad_move, m_bad);
`endif
    end
  end

  // ---- stimulus helpers
  task automatic step1(input bit t, input bit p);
    bif.frame_tick   = t;
    bif.power_pellet = p;
    @(posedge clk);
    #1;
    bif.frame_tick   = 1'b0;
    bif.power_pellet = 1'b0;
  endtask

  task automatic frames(input int n);
    repeat (n) begin
      step1(1'b1, 1'b0);
      repeat (9) step1(1'b0, 1'b0);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step1(1'b0, 1'b0);
    step1(1'b0, 1'b0);
    rst_n = 1'b1;
  endtask

  logic [35:0] st_log, hit_log, bad_log;

  // Final tick of a period, then nine logged cycles covering the whole round.
  task automatic run_round();
    st_log = '0; hit_log = '0; bad_log = '0;
    for (int k = 0; k < 9; k++) begin
      step1(k == 0, 1'b0);
      st_log[4*k +: 4]  = bif.step;
      hit_log[4*k +: 4] = bif.hit;
`ifdef GHOST_BOUNDS_CHECK_EN
      bad_log[4*k +: 4] = bif.bad_move;
`endif
    end
    step1(1'b0, 1'b0);
  endtask

  function automatic logic [3:0] or_nibbles(input logic [35:0] v);
    logic [3:0] r = '0;
    for (int k = 0; k < 9; k++) r |= v[4*k +: 4];
    return r;
  endfunction

  typedef struct {
    logic [39:0] nx;
    logic [35:0] ny;
    logic [9:0]  px;
    logic [8:0]  py;
    logic [39:0] egx;
    logic [35:0] egy;
    logic [3:0]  ehit;
  } vec_t;

  vec_t tbl [4];

  initial begin
    int first;
    bit seen, pp;
    int gsel;

    tbl[0] = '{nx: {10'd80, 10'd60, 10'd40, 10'd20}, ny: {9'd100, 9'd80, 9'd60, 9'd40},
               px: 10'd20, py: 9'd40,
               egx: {10'd80, 10'd60, 10'd40, 10'd20}, egy: {9'd100, 9'd80, 9'd60, 9'd40},
               ehit: 4'b0001};
    tbl[1] = '{nx: {4{10'd600}}, ny: {4{9'd320}}, px: 10'd600, py: 9'd320,
               egx: {4{10'd600}}, egy: {4{9'd320}}, ehit: 4'b1111};
    tbl[2] = '{nx: {10'd0, 10'd620, 10'd0, 10'd620}, ny: {9'd460, 9'd0, 9'd0, 9'd460},
               px: 10'd620, py: 9'd0,
               egx: {10'd0, 10'd620, 10'd0, 10'd620}, egy: {9'd460, 9'd0, 9'd0, 9'd460},
               ehit: 4'b0100};
    tbl[3] = '{nx: {10'd100, 10'd200, 10'd300, 10'd400}, ny: {9'd20, 9'd40, 9'd60, 9'd80},
               px: 10'd400, py: 9'd40,
               egx: {10'd100, 10'd200, 10'd300, 10'd400}, egy: {9'd20, 9'd40, 9'd60, 9'd80},
               ehit: 4'b0000};

    bif.frame_tick = 1'b0; bif.power_pellet = 1'b0;
    bif.pac_x = '0; bif.pac_y = '0;
    bif.nxt_x = HX; bif.nxt_y = HY;

    // Reset state
    repeat (3) step1(1'b0, 1'b0);
    chk("rst_step", bif.step, 4'b0);
    chk("rst_hit", bif.hit, 4'b0);
    chk("rst_fright", bif.frightened, 1'b0);
    chk("rst_cur", {bif.cur_x, bif.cur_y}, 19'd0);
    chk("rst_gx", bif.ghost_x, HX);
    chk("rst_gy", bif.ghost_y, HY);
    rst_n  = 1'b1;
    chk_en = 1'b1;

    // Grant sequence after reset release
    bif.nxt_x = {10'd160, 10'd120, 10'd80, 10'd40};
    bif.nxt_y = {9'd140, 9'd100, 9'd60, 9'd20};
    frames(SF - 1);
    chk("pre_round_step", bif.step, 4'b0);
    run_round();
    chk("grant_seq", st_log, 36'h080402010);
    chk("grant_gx", bif.ghost_x, {10'd160, 10'd120, 10'd80, 10'd40});
    chk("grant_gy", bif.ghost_y, {9'd140, 9'd100, 9'd60, 9'd20});

    // Collision on ghost2 only
    bif.nxt_x = {10'd60, 10'd600, 10'd40, 10'd20};
    bif.nxt_y = {9'd60, 9'd340, 9'd40, 9'd20};
    bif.pac_x = 10'd600; bif.pac_y = 9'd340;
    frames(SF - 1);
    run_round();
    chk("hit_seq", hit_log, 36'h004000000);

    for (int i = 0; i < 4; i++) begin
      bif.nxt_x = tbl[i].nx; bif.nxt_y = tbl[i].ny;
      bif.pac_x = tbl[i].px; bif.pac_y = tbl[i].py;
      frames(SF - 1);
      run_round();
      chk($sformatf("vec%0d_gx", i), bif.ghost_x, tbl[i].egx);
      chk($sformatf("vec%0d_gy", i), bif.ghost_y, tbl[i].egy);
      chk($sformatf("vec%0d_hit", i), or_nibbles(hit_log), tbl[i].ehit);
    end

    // Frightened timer: set, then clears after FF ticks
    step1(1'b0, 1'b1);
    chk("fr_set", bif.frightened, 1'b1);
    frames(FF - 1);
    chk("fr_hold", bif.frightened, 1'b1);
    frames(1);
    chk("fr_clear", bif.frightened, 1'b0);

    // Pellet on the final decrement reloads the full count
    step1(1'b0, 1'b1);
    frames(FF - 1);
    step1(1'b1, 1'b1);
    repeat (9) step1(1'b0, 1'b0);
    chk("fr_reload", bif.frightened, 1'b1);
    frames(FF - 1);
    chk("fr_reload_hold", bif.frightened, 1'b1);
    frames(1);
    chk("fr_reload_clear", bif.frightened, 1'b0);

    // Doubled step period while kept frightened
    do_reset();
    step1(1'b0, 1'b1);
    first = 0;
    for (int i = 1; i <= 2*SF; i++) begin
      step1(1'b1, 1'b1);
      seen = 1'b0;
      repeat (9) begin
        step1(1'b0, 1'b0);
        if (bif.step != '0) seen = 1'b1;
      end
      if (seen && first == 0) first = i;
    end
    chk("fright_period", first, 2*SF);
    frames(FF);
    chk("fright_end", bif.frightened, 1'b0);

    // Reset during ghost1 capture
    do_reset();
    bif.nxt_x = {4{10'd20}}; bif.nxt_y = {4{9'd20}};
    frames(SF - 1);
    step1(1'b1, 1'b0);
    repeat (3) step1(1'b0, 1'b0);
    chk("cap1_step", bif.step, 4'b0010);
    rst_n = 1'b0;
    #1;
    chk("midrst_step", bif.step, 4'b0);
    chk("midrst_gx", bif.ghost_x, HX);
    chk("midrst_gy", bif.ghost_y, HY);
    step1(1'b0, 1'b0);
    rst_n = 1'b1;

    // Out-of-bounds proposal for ghost0
    bif.nxt_x = {10'd20, 10'd20, 10'd20, 10'd640};
    bif.nxt_y = {4{9'd20}};
    frames(SF - 1);
    run_round();
`ifdef GHOST_BOUNDS_CHECK_EN
    chk("oob_held", bif.ghost_x[9:0], 10'd600);
    chk("oob_bad", or_nibbles(bad_log), 4'b0001);
`else
    chk("oob_commit", bif.ghost_x[9:0], 10'd640);
`endif
    chk("oob_other", bif.ghost_x[19:10], 10'd20);

    // Randomized frames against the model
    do_reset();
    for (int f = 0; f < 300; f++) begin
      for (int g = 0; g < NG; g++) begin
        if ($urandom_range(0, 3) != 0) begin
          bif.nxt_x[10*g +: 10] = 10'(20 * $urandom_range(0, 31));
          bif.nxt_y[9*g +: 9]   = 9'(20 * $urandom_range(0, 23));
        end else begin
          bif.nxt_x[10*g +: 10] = 10'($urandom_range(0, 1023));
          bif.nxt_y[9*g +: 9]   = 9'($urandom_range(0, 511));
        end
      end
      if ($urandom_range(0, 1) == 1) begin
        gsel = $urandom_range(0, NG-1);
        bif.pac_x = bif.nxt_x[10*gsel +: 10];
        bif.pac_y = bif.nxt_y[9*gsel +: 9];
      end else begin
        bif.pac_x = 10'(20 * $urandom_range(0, 31));
        bif.pac_y = 9'(20 * $urandom_range(0, 23));
      end
      pp = ($urandom_range(0, 7) == 0);
      step1(1'b1, pp);
      repeat ($urandom_range(9, 12)) step1(1'b0, $urandom_range(0, 31) == 0);
    end

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
